// File: rtl/ball_collision_resolver.sv
// ball_collision_resolver: turns collision requests into one-cycle velocity writes, with a per-frame cooldown.
// Optional macro COLLISION_COUNTER_EN enables the saturating resolved-collision counter.
module ball_collision_resolver #(
    parameter int VELOCITY_LIMIT  = 200,
    parameter int COOLDOWN_FRAMES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        startOfFrame,
    input  logic        collisionReq,
    input  logic [2:0]  collisionType,
    input  logic [10:0] ballAPosX,
    input  logic [10:0] ballAPosY,
    input  logic [10:0] ballBPosX,
    input  logic [10:0] ballBPosY,
    input  logic [10:0] ballAVelX,
    input  logic [10:0] ballAVelY,
    input  logic [10:0] ballBVelX,
    input  logic [10:0] ballBVelY,
    output logic        ballAWriteEnable,
    output logic [10:0] ballAOutVelX,
    output logic [10:0] ballAOutVelY,
    output logic        ballBWriteEnable,
    output logic [10:0] ballBOutVelX,
    output logic [10:0] ballBOutVelY,
    output logic        busy,
    output logic        requestDropped,
    output logic [15:0] collisionCount
);
    typedef enum logic [1:0] {IDLE, EVALUATE, WRITE, COOLDOWN} state_t;
    localparam int CW = $clog2(COOLDOWN_FRAMES + 2);
    localparam logic signed [11:0] LIM = 12'(VELOCITY_LIMIT);

    state_t state, nextState;
    logic [CW-1:0] cdCnt;
    logic cdDone;
    logic [2:0] capType;
    logic [10:0] aPx, aPy, bPx, bPy, aVx, aVy, bVx, bVy;
    logic signed [11:0] aX, aY, bX, bY, dx, dy, relX, relY, nAx, nAy, nBx, nBy;
    logic [11:0] adx, ady;
    logic apprX, apprY, weA, weB;

    function automatic logic [10:0] sat(input logic signed [11:0] v);
        return v > LIM ? 11'(LIM) : (v < -LIM ? 11'(-LIM) : v[10:0]);
    endfunction

    assign aX = {aVx[10], aVx};
    assign aY = {aVy[10], aVy};
    assign bX = {bVx[10], bVx};
    assign bY = {bVy[10], bVy};
    assign dx = $signed({1'b0, bPx}) - $signed({1'b0, aPx});
    assign dy = $signed({1'b0, bPy}) - $signed({1'b0, aPy});
    assign adx = dx[11] ? -dx : dx;
    assign ady = dy[11] ? -dy : dy;
    assign relX = aX - bX;
    assign relY = aY - bY;
    // Sign agreement of offset and relative velocity stands in for a dot-product test.
    assign apprX = adx >= ady && dx != '0 && relX != '0 && dx[11] == relX[11];
    assign apprY = ady >= adx && dy != '0 && relY != '0 && dy[11] == relY[11];
    assign busy = state != IDLE;
    assign cdDone = startOfFrame && cdCnt == CW'(COOLDOWN_FRAMES - 1);

    always_comb begin
        nAx = aX;
        nAy = aY;
        nBx = bX;
        nBy = bY;
        weA = 1'b0;
        weB = 1'b0;
        case (capType)
            3'd0: begin
                weA = apprX | apprY;
                weB = apprX | apprY;
                nAx = apprX ? bX : aX;
                nBx = apprX ? aX : bX;
                nAy = apprY ? bY : aY;
                nBy = apprY ? aY : bY;
            end
            3'd1: begin
                weA = aVx[10];
                nAx = -aX;
            end
            3'd2: begin
                weA = !aVx[10] && aVx != '0;
                nAx = -aX;
            end
            3'd3: begin
                weA = aVy[10];
                nAy = -aY;
            end
            3'd4: begin
                weA = !aVy[10] && aVy != '0;
                nAy = -aY;
            end
            default: ;
        endcase
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:     nextState = collisionReq ? EVALUATE : IDLE;
            EVALUATE: nextState = weA ? WRITE : IDLE;
            WRITE:    nextState = COOLDOWN_FRAMES == 0 ? IDLE : COOLDOWN;
            COOLDOWN: nextState = cdDone ? IDLE : COOLDOWN;
            default:  nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cdCnt <= '0;
            capType <= '0;
            aPx <= '0;
            aPy <= '0;
            bPx <= '0;
            bPy <= '0;
            aVx <= '0;
            aVy <= '0;
            bVx <= '0;
            bVy <= '0;
            ballAWriteEnable <= 1'b0;
            ballBWriteEnable <= 1'b0;
            ballAOutVelX <= '0;
            ballAOutVelY <= '0;
            ballBOutVelX <= '0;
            ballBOutVelY <= '0;
            requestDropped <= 1'b0;
        end else begin
            state <= nextState;
            cdCnt <= state == COOLDOWN ? cdCnt + CW'(startOfFrame) : '0;
            ballAWriteEnable <= state == EVALUATE && weA;
            ballBWriteEnable <= state == EVALUATE && weB;
            requestDropped <= collisionReq && state != IDLE;
            if (state == IDLE && collisionReq) begin
                capType <= collisionType;
                aPx <= ballAPosX;
                aPy <= ballAPosY;
                bPx <= ballBPosX;
                bPy <= ballBPosY;
                aVx <= ballAVelX;
                aVy <= ballAVelY;
                bVx <= ballBVelX;
                bVy <= ballBVelY;
            end
            if (state == EVALUATE && weA) begin
                ballAOutVelX <= sat(nAx);
                ballAOutVelY <= sat(nAy);
            end
            if (state == EVALUATE && weB) begin
                ballBOutVelX <= sat(nBx);
                ballBOutVelY <= sat(nBy);
            end
        end
    end

`ifdef COLLISION_COUNTER_EN
    always_ff @(posedge clk) begin
        if (reset)
            collisionCount <= '0;
        else if (state == WRITE && collisionCount != 16'hFFFF)
            collisionCount <= collisionCount + 16'd1;
    end
`else
    assign collisionCount = '0;
`endif
endmodule
